// File: rtl/booth_nonrestoring_divider_if.sv
// Start/result handshake bundle for the sequential signed divider.
interface booth_nonrestoring_divider_if #(
  parameter int unsigned N = 4
);
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;
  logic         overflow;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/booth_nonrestoring_divider.sv
// Sequential signed radix-2 non-restoring divider: magnitudes are divided over N
// steps, then a single fix-up cycle restores the remainder and applies the signs.
module booth_nonrestoring_divider #(
  parameter int unsigned N = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  booth_nonrestoring_divider_if.slave  bus
);
  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t         state_q, state_d;
  logic [N:0]     p_q, p_d;
  logic [N-1:0]   q_q, q_d;
  logic [N-1:0]   d_q, d_d;
  logic           sa_q, sa_d;
  logic           sb_q, sb_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [N-1:0]   quot_q, quot_d;
  logic [N-1:0]   rem_q, rem_d;
  logic           dbz_q, dbz_d;
  logic           ovf_q, ovf_d;

  logic [N-1:0]   a_mag, b_mag;
  logic [N:0]     p_sh, p_new, p_fix;

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    q_d     = q_q;
    d_d     = d_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;

    a_mag = bus.dividend[N-1] ? -bus.dividend : bus.dividend;
    b_mag = bus.divisor[N-1]  ? -bus.divisor  : bus.divisor;
    // Shift {P,Q} left, then add or subtract D depending on the sign of P.
    p_sh  = {p_q[N-1:0], q_q[N-1]};
    p_new = p_q[N] ? (p_sh + {1'b0, d_q}) : (p_sh - {1'b0, d_q});
    p_fix = p_q[N] ? (p_q + {1'b0, d_q}) : p_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          q_d     = a_mag;
          d_d     = b_mag;
          sa_d    = bus.dividend[N-1];
          sb_d    = bus.divisor[N-1];
          p_d     = '0;
          cnt_d   = CW'(N);
          busy_d  = 1'b1;
          state_d = (bus.divisor == '0) ? FIX : RUN;
        end
      end
      RUN: begin
        p_d   = p_new;
        q_d   = {q_q[N-2:0], ~p_new[N]};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
        if (d_q == '0) begin
          // Q still holds |dividend| since no RUN steps were taken.
          quot_d = '1;
          rem_d  = sa_q ? -q_q : q_q;
          dbz_d  = 1'b1;
          ovf_d  = 1'b0;
        end else begin
          quot_d = (sa_q ^ sb_q) ? -q_q : q_q;
          rem_d  = sa_q ? -p_fix[N-1:0] : p_fix[N-1:0];
          dbz_d  = 1'b0;
          // A non-negative quotient with its top bit set can only be -2^(N-1)/-1.
          ovf_d  = ~(sa_q ^ sb_q) & q_q[N-1];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      p_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      q_q     <= q_d;
      d_q     <= d_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_booth_nonrestoring_divider.sv
// Directed and exhaustive checks of the N=4 signed non-restoring divider.
module tb_booth_nonrestoring_divider;
  logic clk;
  logic rst_n;

  booth_nonrestoring_divider_if #(.N(4)) bus_if ();

  booth_nonrestoring_divider #(.N(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
    logic       dz;
    logic       ov;
  } vec_t;

  vec_t tbl [12];
  int   n_cmp;
  int   n_err;
  int   lat;
  int   bcnt;
  int   seen;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [9:0] res();
    return {bus_if.div_by_zero, bus_if.overflow, bus_if.quotient, bus_if.remainder};
  endfunction

  function automatic logic [9:0] model(input logic signed [3:0] a, input logic signed [3:0] b);
    logic signed [3:0] q;
    logic signed [3:0] r;
    if (b == 4'sb0000) return {1'b1, 1'b0, 4'hF, a};
    if (a == 4'sb1000 && b == 4'sb1111) return {1'b0, 1'b1, 4'b1000, 4'b0000};
    q = a / b;
    r = a % b;
    return {2'b00, q, r};
  endfunction

  // Issue one request and wait (bounded) for done; lat counts edges after acceptance.
  task automatic run_div(input logic [3:0] a, input logic [3:0] b,
                         output int l, output int bc);
    @(negedge clk);
    bus_if.start    = 1'b1;
    bus_if.dividend = a;
    bus_if.divisor  = b;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    l  = 0;
    bc = bus_if.busy ? 1 : 0;
    while (!bus_if.done && l < 20) begin
      @(posedge clk); #1;
      l++;
      if (bus_if.busy) bc++;
    end
    if (!bus_if.done) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout %0h/%0h: done never rose", a, b);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    tbl[0]  = '{4'd7,    4'd2,    4'd3,    4'd1,    1'b0, 1'b0};
    tbl[1]  = '{4'b1001, 4'd2,    4'b1101, 4'b1111, 1'b0, 1'b0};
    tbl[2]  = '{4'd7,    4'b1110, 4'b1101, 4'd1,    1'b0, 1'b0};
    tbl[3]  = '{4'b1001, 4'b1110, 4'd3,    4'b1111, 1'b0, 1'b0};
    tbl[4]  = '{4'b1000, 4'b1111, 4'b1000, 4'd0,    1'b0, 1'b1};
    tbl[5]  = '{4'b1000, 4'd1,    4'b1000, 4'd0,    1'b0, 1'b0};
    tbl[6]  = '{4'd5,    4'd0,    4'hF,    4'd5,    1'b1, 1'b0};
    tbl[7]  = '{4'b1101, 4'd0,    4'hF,    4'b1101, 1'b1, 1'b0};
    tbl[8]  = '{4'd0,    4'd5,    4'd0,    4'd0,    1'b0, 1'b0};
    tbl[9]  = '{4'b1000, 4'd3,    4'b1110, 4'b1110, 1'b0, 1'b0};
    tbl[10] = '{4'd7,    4'd7,    4'd1,    4'd0,    1'b0, 1'b0};
    tbl[11] = '{4'b1111, 4'd7,    4'd0,    4'b1111, 1'b0, 1'b0};

    rst_n = 1'b0;
    bus_if.start    = 1'b0;
    bus_if.dividend = '0;
    bus_if.divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {6'd0, bus_if.busy, bus_if.done, bus_if.div_by_zero, bus_if.overflow,
                        bus_if.quotient, bus_if.remainder}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_div(tbl[i].a, tbl[i].b, lat, bcnt);
      chk($sformatf("vec%0d_result", i), 16'(res()),
          16'({tbl[i].dz, tbl[i].ov, tbl[i].q, tbl[i].r}));
      chk($sformatf("vec%0d_latency", i), 16'(lat), (tbl[i].b == 4'd0) ? 16'd1 : 16'd5);
      if (i == 0) chk("vec0_busy_cycles", 16'(bcnt), 16'd5);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_done_pulse", i), 16'(bus_if.done), 16'd0);
      chk($sformatf("vec%0d_hold", i), 16'(res()),
          16'({tbl[i].dz, tbl[i].ov, tbl[i].q, tbl[i].r}));
    end

    // Start pulsed mid-RUN with new operands must be ignored.
    @(negedge clk);
    bus_if.start = 1'b1; bus_if.dividend = 4'd7; bus_if.divisor = 4'd2;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    lat = 0;
    repeat (2) begin @(posedge clk); #1; lat++; end
    bus_if.start = 1'b1; bus_if.dividend = 4'b1000; bus_if.divisor = 4'd3;
    @(posedge clk); #1;
    lat++;
    bus_if.start = 1'b0;
    while (!bus_if.done && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("ignore_start_result", 16'(res()), 16'({2'b00, 4'd3, 4'd1}));
    chk("ignore_start_latency", 16'(lat), 16'd5);

    // Reset mid-RUN clears outputs at once and produces no done.
    @(negedge clk);
    bus_if.start = 1'b1; bus_if.dividend = 4'd5; bus_if.divisor = 4'd2;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", {6'd0, bus_if.busy, bus_if.done, bus_if.div_by_zero, bus_if.overflow,
                          bus_if.quotient, bus_if.remainder}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin @(posedge clk); #1; if (bus_if.done || bus_if.busy) seen++; end
    chk("abort_no_done", 16'(seen), 16'd0);

    // Exhaustive pairs with start held high: each next request lands in the done cycle.
    @(negedge clk);
    bus_if.start = 1'b1; bus_if.dividend = 4'd0; bus_if.divisor = 4'd0;
    @(posedge clk); #1;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] cur;
      logic [7:0] nx;
      cur = 8'(i);
      nx  = 8'(i + 1);
      if (i < 255) begin
        bus_if.dividend = nx[7:4];
        bus_if.divisor  = nx[3:0];
      end else begin
        bus_if.start = 1'b0;
      end
      lat = 0;
      while (!bus_if.done && lat < 20) begin @(posedge clk); #1; lat++; end
      chk($sformatf("exh_%0d_%0d", $signed(cur[7:4]), $signed(cur[3:0])),
          16'(res()), 16'(model(cur[7:4], cur[3:0])));
      if (i < 255) begin @(posedge clk); #1; end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
